// File: rtl/matrix_keypad_scanner_pkg.sv
// keypad_pkg: shared types, sizes and helper functions for the keypad scanner
// and its tick prescaler.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  // Clocks per column-advance tick.
  function automatic int calc_tick_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Index of the single asserted bit in a one-hot row vector (0 if not one-hot).
  function automatic logic [1:0] onehot_idx(input logic [ROWS-1:0] lo);
    logic [1:0] idx;
    case (lo)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/matrix_keypad_scanner_if.sv
// keypad_if: keypad pins plus the decoded key outputs. The scanner is the
// master; the keypad/consumer side is the slave.
interface keypad_if;
  import keypad_pkg::*;

  logic [ROWS-1:0]  row_in;
  logic [COLS-1:0]  col_out;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/matrix_keypad_scanner_scan_tick_gen.sv
// scan_tick_gen: free-running prescaler counting 0..TICK_DIV-1; tick_o is
// high for the one cycle the count sits at its terminal value.
module scan_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap to zero at terminal count.
  always_comb begin
    cnt_d = (cnt_q == TC) ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == TC);

endmodule

// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner: scans a 4x4 active-low keypad one column at a time,
// debounces press and release, and reports one key code per press.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SCAN     | advancing columns on each tick, looking for a single low row
// PRESS_DB | column frozen, counting consecutive ticks with the row low
// HELD     | key accepted, waiting for the latched row to go high
// REL_DB   | counting consecutive ticks with the latched row high
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int         TICK_DIV = calc_tick_div(CLK_HZ, SCAN_HZ);
  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_TICKS);

  logic             tick;
  logic [ROWS-1:0]  sync1_q, rs_q;
  kp_state_e        state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [COLS-1:0]  col_out_q;

  logic [ROWS-1:0]  row_lo;
  logic             one_low;
  logic [1:0]       row_sel;
  logic             latched_alone_low;
  logic             latched_high;
  logic [7:0]       cnt_inc;

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep_q, rep_d;
  logic        rep_armed_q, rep_armed_d;
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_DELAY == REPEAT_PERIOD);
`endif

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      rs_q    <= '1;
    end else begin
      sync1_q <= kp.row_in;
      rs_q    <= sync1_q;
    end
  end

  assign row_lo            = ~rs_q;
  assign one_low           = (row_lo != '0) && ((row_lo & (row_lo - 4'd1)) == '0);
  assign row_sel           = onehot_idx(row_lo);
  assign latched_alone_low = (rs_q == ~(4'b0001 << row_idx_q));
  assign latched_high      = rs_q[row_idx_q];
  assign cnt_inc           = cnt_q + 8'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  // Next-state and output decisions, all taken on the scan tick.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_low) begin
            row_idx_d = row_sel;
            cnt_d     = 8'd1;
            if (DB_LAST <= 8'd1) begin
              key_code_d  = {row_sel, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end else begin
            // Idle column or ambiguous multi-row pattern: move on.
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        PRESS_DB: begin
          if (latched_alone_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LAST) begin
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end
          end else begin
            // Bounce: rescan the same column on the next tick.
            state_d = SCAN;
          end
        end
        HELD: begin
          if (latched_high) begin
            cnt_d   = 8'd1;
            state_d = REL_DB;
          end
        end
        REL_DB: begin
          if (latched_high) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LAST) begin
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = SCAN;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end

`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
    rep_armed_d = rep_armed_q;
    if (state_d == HELD && state_q != HELD) begin
      rep_d       = '0;
      rep_armed_d = 1'b0;
    end else if (tick && state_q == HELD && state_d == HELD) begin
      rep_d = rep_q + 16'd1;
      if (rep_d == (rep_armed_q ? 16'(REPEAT_PERIOD) : 16'(REPEAT_DELAY))) begin
        key_valid_d = 1'b1;
        rep_d       = '0;
        rep_armed_d = 1'b1;
      end
    end
`endif
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cnt_q       <= 8'd0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_out_q   <= 4'b1110;
    end else begin
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      col_out_q   <= ~(4'b0001 << col_idx_d);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat counter, only meaningful while HELD.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`endif

  assign kp.col_out   = col_out_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with TICK_DIV=10, DEBOUNCE_TICKS=3.
// A behavioural keypad pulls a row low when its key is down and its column
// is driven low. Cycle numbers count posedges since reset release.
module tb_matrix_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] key_down;
  int          cyc;
  int          pulse_cnt;
  int          n_assert;
  int          n_fail;
  int          base;

  keypad_if kp_if ();

  matrix_keypad_scanner #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_TICKS (3),
    .REPEAT_DELAY   (5),
    .REPEAT_PERIOD  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: key index {row,col} pulls its row low while its column is driven.
  always_comb begin
    kp_if.row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !kp_if.col_out[c]) kp_if.row_in[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial pulse_cnt = 0;
  always @(posedge clk) if (kp_if.key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge; holds rst for three posedges and checks outputs meanwhile.
  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", {15'd0, kp_if.key_valid}, 16'd0);
    chk("rst_held",  {15'd0, kp_if.key_held},  16'd0);
    chk("rst_code",  {12'd0, kp_if.key_code},  16'd0);
    chk("rst_col",   {12'd0, kp_if.col_out},   16'hE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    key_down = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset values and idle column rotation.
    apply_reset();
    chk("init_col",   {12'd0, kp_if.col_out},   16'hE);
    chk("init_valid", {15'd0, kp_if.key_valid}, 16'd0);
    chk("init_held",  {15'd0, kp_if.key_held},  16'd0);
    chk("init_code",  {12'd0, kp_if.key_code},  16'd0);
    wait_until(9);  chk("col_c9",  {12'd0, kp_if.col_out}, 16'hE);
    wait_until(10); chk("col_c10", {12'd0, kp_if.col_out}, 16'hD);
    wait_until(25); chk("col_c25", {12'd0, kp_if.col_out}, 16'hB);
    wait_until(35); chk("col_c35", {12'd0, kp_if.col_out}, 16'h7);
    wait_until(45); chk("col_wrap", {12'd0, kp_if.col_out}, 16'hE);

    // Steady press of key 9 (row 2, col 1): detect at tick 20, accept at tick 40.
    apply_reset();
    base = pulse_cnt;
    key_down = 16'h0200;
    wait_until(25); chk("k9_col_frozen", {12'd0, kp_if.col_out}, 16'hD);
    wait_until(39); chk("k9_pre_valid", {15'd0, kp_if.key_valid}, 16'd0);
    wait_until(40);
    chk("k9_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("k9_code",  {12'd0, kp_if.key_code},  16'h9);
    chk("k9_held",  {15'd0, kp_if.key_held},  16'd1);
    wait_until(41); chk("k9_pulse_end", {15'd0, kp_if.key_valid}, 16'd0);
    wait_until(203);
    chk("k9_one_pulse", 16'(pulse_cnt - base), 16'd1);
    chk("k9_still_held", {15'd0, kp_if.key_held}, 16'd1);
    key_down = 16'h0000;
    wait_until(229); chk("k9_rel_held", {15'd0, kp_if.key_held}, 16'd1);
    wait_until(230);
    chk("k9_rel_clear", {15'd0, kp_if.key_held}, 16'd0);
    chk("k9_rel_adv",   {12'd0, kp_if.col_out},  16'hB);
    chk("k9_code_kept", {12'd0, kp_if.key_code}, 16'h9);

    // Bounce on alternate ticks, then steady: accept at tick 100.
    apply_reset();
    base = pulse_cnt;
    wait_until(5);  key_down = 16'h0200;
    wait_until(25); key_down = 16'h0000;
    wait_until(35); key_down = 16'h0200;
    wait_until(45); key_down = 16'h0000;
    wait_until(55); key_down = 16'h0200;
    wait_until(65); key_down = 16'h0000;
    wait_until(75); key_down = 16'h0200;
    chk("bnc_col_frozen", {12'd0, kp_if.col_out}, 16'hD);
    wait_until(99);
    chk("bnc_no_pulse", 16'(pulse_cnt - base), 16'd0);
    chk("bnc_pre_valid", {15'd0, kp_if.key_valid}, 16'd0);
    wait_until(100);
    chk("bnc_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("bnc_code",  {12'd0, kp_if.key_code},  16'h9);
    wait_until(101); chk("bnc_pulse_end", {15'd0, kp_if.key_valid}, 16'd0);
    key_down = 16'h0000;

    // Ghost: rows 0 and 3 in column 2 are skipped; then row 1 alone gives 6.
    apply_reset();
    base = pulse_cnt;
    key_down = 16'h4004;
    wait_until(35); chk("gh_skip_c35", {12'd0, kp_if.col_out}, 16'h7);
    wait_until(75);
    chk("gh_skip_c75", {12'd0, kp_if.col_out}, 16'h7);
    chk("gh_no_pulse", 16'(pulse_cnt - base), 16'd0);
    key_down = 16'h0040;
    wait_until(129); chk("k6_pre_valid", {15'd0, kp_if.key_valid}, 16'd0);
    wait_until(130);
    chk("k6_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("k6_code",  {12'd0, kp_if.key_code},  16'h6);
    wait_until(140); chk("k6_one_pulse", 16'(pulse_cnt - base), 16'd1);
    key_down = 16'h0000;

    // Reset during PRESS_DB and during HELD while key F stays down.
    apply_reset();
    base = pulse_cnt;
    key_down = 16'h8000;
    wait_until(45);
    apply_reset();
    chk("rpd_no_pulse", 16'(pulse_cnt - base), 16'd0);
    wait_until(59); chk("rpd_pre_valid", {15'd0, kp_if.key_valid}, 16'd0);
    wait_until(60);
    chk("rpd_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("rpd_code",  {12'd0, kp_if.key_code},  16'hF);
    wait_until(75);
    apply_reset();
    chk("rhd_one_pulse", 16'(pulse_cnt - base), 16'd1);
    wait_until(60);
    chk("rhd_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("rhd_code",  {12'd0, kp_if.key_code},  16'hF);
    chk("rhd_held",  {15'd0, kp_if.key_held},  16'd1);
    wait_until(61); chk("rhd_two_pulses", 16'(pulse_cnt - base), 16'd2);

    // Continue holding key F for 12 ticks past the accept at tick 60.
    base = pulse_cnt;
    wait_until(185);
`ifdef KEYPAD_REPEAT_EN
    chk("repeat_pulses", 16'(pulse_cnt - base), 16'd4);
`else
    chk("repeat_pulses", 16'(pulse_cnt - base), 16'd0);
`endif
    chk("repeat_code", {12'd0, kp_if.key_code}, 16'hF);
    key_down = 16'h0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_scanner.md
# matrix_keypad_scanner

Scans a 4x4 active-low matrix keypad and turns debounced presses into a 4-bit key code plus a one-cycle valid pulse. It is the input-side counterpart of the multiplexed display scanner: it drives one column at a time instead of one digit at a time, and reads rows back. It sits between the keypad pins and the clock controller, and provides direct digit entry as an alternative to the mode/increment keys.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- SCAN_HZ, 1000, column-advance tick rate; TICK_DIV = CLK_HZ/SCAN_HZ, which must be ≥ 4.
- DEBOUNCE_TICKS, 20, consecutive stable ticks needed to accept a press or a release (1..255).
- REPEAT_DELAY, 500, ticks held before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_PERIOD, 100, ticks between subsequent repeats (KEYPAD_REPEAT_EN only).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- row_in  in  4  keypad rows; active-low, externally pulled up, asynchronous to clk.
- col_out  out  4  column drive; active-low, exactly one bit low at all times.
- key_code  out  4  last accepted key, {row[1:0], col[1:0]}; holds its value until the next accept.
- key_valid  out  1  one-cycle pulse when key_code is updated.
- key_held  out  1  high from accept until release is debounced.

## Operation
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- A prescaler counts 0..TICK_DIV-1 and produces `tick` for one cycle at terminal count. It runs freely in every state.
- The column index col_idx (2 bits) selects col_out = ~(4'b0001 << col_idx).
- States are SCAN, PRESS_DB, HELD, REL_DB.
- SCAN: on tick, evaluate rs for the current column.
  - All rows high: advance col_idx (3 wraps to 0).
  - Exactly one row low: latch row_idx and col_idx, set cnt=1, go to PRESS_DB. The column stays frozen.
  - Two or more rows low (ghosting/ambiguous): ignore the column and advance.
- PRESS_DB: on tick, check the latched row.
  - Latched row alone low: cnt++. When cnt reaches DEBOUNCE_TICKS, load key_code, pulse key_valid, set key_held, go to HELD.
  - Any other rs pattern: go to SCAN with no output and no column advance on that tick.
- HELD: on tick, if the latched row is high, set cnt=1 and go to REL_DB. Otherwise stay.
- REL_DB: on tick, check the latched row.
  - Latched row high: cnt++. When cnt reaches DEBOUNCE_TICKS, clear key_held, go to SCAN, and advance col_idx.
  - Latched row low: go back to HELD.
- The column is frozen in PRESS_DB, HELD and REL_DB, so a second key pressed meanwhile is never reported. Only one key is reported per press/release cycle.
- If DEBOUNCE_TICKS = 1, the accept happens on the same tick that enters PRESS_DB: SCAN goes directly to HELD and pulses key_valid.
- Reset values: state SCAN, col_idx 0, col_out 4'b1110, key_code 0, key_valid 0, key_held 0, prescaler 0, cnt 0, synchronizer flops 4'b1111.
- A reset asserted mid-press or mid-hold aborts without a pulse. After reset, a key that is still down is re-detected from SCAN and reported once.

## Timing
- All outputs are registered.
- key_valid is high exactly in the cycle after the tick that completes the debounce count.
- Each column dwells for TICK_DIV cycles, so the row lines settle well beyond the 2-cycle synchronizer latency.
- Minimum press-to-pulse latency is DEBOUNCE_TICKS ticks. Worst case adds 3 ticks of column scan.
- There is no handshake: the consumer must sample key_code while key_valid is high. key_code is stable from that cycle until the next pulse.

## Configuration
- Macro KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter counts ticks. key_valid re-pulses with the same key_code after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks, until the state leaves HELD. The counter resets on entry to HELD and on REL_DB→HELD bounce-back.
- Undefined: exactly one key_valid per press. The repeat counter and both REPEAT parameters are unused.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, PRESS_DB, HELD, REL_DB);
  - KEY_W = 4, ROWS = 4, COLS = 4;
  - the function that computes TICK_DIV from CLK_HZ and SCAN_HZ.
- One sub-module, scan_tick_gen: the prescaler, parameterized by TICK_DIV, with a tick output. It is reusable by the display scanner.
- Everything else stays in a single FSM module.

## Test plan
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (TICK_DIV=10) and DEBOUNCE_TICKS=3.
- Reset → col_out=4'b1110, key_valid=0, key_held=0, key_code=0. With no key pressed, col_out cycles 1110→1101→1011→0111→1110, one step every 10 clocks.
- Hold the key at row 2/col 1 steadily → exactly one key_valid with key_code=4'h9. key_held stays high until release, then clears 3 ticks after release.
- Bounce row 2 low/high on alternate ticks for 6 ticks, then hold it → no pulse during the bounce, then one pulse with code 4'h9.
- Rows 0 and 3 both low in column 2 → no pulse and scanning continues. Next, press row 1 alone in column 2 → code 4'h6.
- Hold key 4'hF and assert rst in PRESS_DB and again in HELD → no pulse while reset is active. After release of rst, one pulse with 4'hF.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=2, hold a key for 12 ticks after accept → pulses at accept+5, +7, +9 and +11 ticks. Without the macro → one pulse only.
